// File: rtl/miner_array_ctrl.sv
// Splits one job nonce range across NUM_CORES hash cores and funnels their
// golden nonces, tagged with core index, through a round-robin arbiter into a result FIFO.
module miner_array_ctrl #(
  parameter int CORE_LOG2     = 2,
  parameter int FIFO_DEPTH    = 8,
  parameter int FLUSH_ON_WORK = 1,
  localparam int NUM_CORES    = 2 ** CORE_LOG2,
  localparam int CW           = (CORE_LOG2 > 0) ? CORE_LOG2 : 1
) (
  input  logic                    hash_clk,
  input  logic                    reset_n,
  input  logic                    new_work,
  input  logic [31:0]             nonce_min,
  input  logic [31:0]             nonce_max,
  output logic [32*NUM_CORES-1:0] core_nonce_min,
  output logic [32*NUM_CORES-1:0] core_nonce_max,
  output logic [NUM_CORES-1:0]    core_en,
  output logic                    core_reset,
  input  logic [NUM_CORES-1:0]    core_found,
  input  logic [32*NUM_CORES-1:0] core_nonce,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [31:0]             out_nonce,
  output logic [CW-1:0]           out_core,
  output logic                    range_err,
  output logic                    overflow,
  output logic [7:0]              drop_cnt
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(FIFO_DEPTH);

  logic [32*NUM_CORES-1:0] min_q, min_d, max_q, max_d;
  logic [NUM_CORES-1:0]    en_q, en_d;
  logic                    core_reset_q, core_reset_d;
  logic                    range_err_q, range_err_d;
  logic                    overflow_q, overflow_d;
  logic [7:0]              drop_q, drop_d;
  logic [NUM_CORES-1:0]    slot_full_q, slot_full_d;
  logic [32*NUM_CORES-1:0] slot_nonce_q, slot_nonce_d;
  logic [CW-1:0]           rr_q, rr_d;
  logic [31:0]             fifo_nonce_q [FIFO_DEPTH];
  logic [31:0]             fifo_nonce_d [FIFO_DEPTH];
  logic [CW-1:0]           fifo_core_q  [FIFO_DEPTH];
  logic [CW-1:0]           fifo_core_d  [FIFO_DEPTH];
  logic [AW-1:0]           wr_q, wr_d, rd_q, rd_d;
  logic [AW:0]             cnt_q, cnt_d;

  logic                    job_valid, flush, grant_valid, push, pop;
  logic [CW-1:0]           grant_idx;
  logic [32:0]             span, chunk;
  logic [4:0]              n_drops;
  logic [8:0]              drop_sum;

  function automatic logic [CW-1:0] rr_index(input logic [CW-1:0] base, input int k);
    return CW'((int'(base) + k) % NUM_CORES);
  endfunction

  always_comb begin
    min_d        = min_q;
    max_d        = max_q;
    en_d         = en_q;
    range_err_d  = range_err_q;
    overflow_d   = overflow_q;
    drop_d       = drop_q;
    slot_full_d  = slot_full_q;
    slot_nonce_d = slot_nonce_q;
    rr_d         = rr_q;
    fifo_nonce_d = fifo_nonce_q;
    fifo_core_d  = fifo_core_q;
    wr_d         = wr_q;
    rd_d         = rd_q;
    cnt_d        = cnt_q;
    span         = '0;
    chunk        = '0;
    grant_valid  = 1'b0;
    grant_idx    = '0;
    n_drops      = '0;
    drop_sum     = '0;

    job_valid    = new_work && (nonce_min <= nonce_max);
    flush        = job_valid && (FLUSH_ON_WORK != 0);
    core_reset_d = job_valid;
    if (new_work) range_err_d = !job_valid;

    // 33-bit span so the full 0..FFFFFFFF job yields 2^32; last core absorbs the remainder
    if (job_valid) begin
      span  = {1'b0, nonce_max} - {1'b0, nonce_min} + 33'd1;
      chunk = span >> CORE_LOG2;
      for (int i = 0; i < NUM_CORES; i++) begin
        if (chunk == '0) begin
          min_d[32*i +: 32] = nonce_min;
          max_d[32*i +: 32] = nonce_max;
          en_d[i]           = (i == 0);
        end else begin
          min_d[32*i +: 32] = nonce_min + 32'(i) * chunk[31:0];
          max_d[32*i +: 32] = (i == NUM_CORES-1) ? nonce_max
                              : nonce_min + 32'(i) * chunk[31:0] + chunk[31:0] - 32'd1;
          en_d[i]           = 1'b1;
        end
      end
    end

    for (int k = 0; k < NUM_CORES; k++) begin
      if (!grant_valid && slot_full_q[rr_index(rr_q, k)]) begin
        grant_valid = 1'b1;
        grant_idx   = rr_index(rr_q, k);
      end
    end
    push = grant_valid && (cnt_q != FULL_CNT);
    pop  = (cnt_q != '0) && out_ready;

    // A flush discards this cycle's grant and found pulses; the RR pointer is left alone
    if (flush) begin
      slot_full_d = '0;
      wr_d        = '0;
      rd_d        = '0;
      cnt_d       = '0;
    end else begin
      if (push) begin
        slot_full_d[grant_idx] = 1'b0;
        fifo_nonce_d[wr_q]     = slot_nonce_q[32*grant_idx +: 32];
        fifo_core_d[wr_q]      = grant_idx;
        wr_d                   = wr_q + 1'b1;
        rr_d                   = rr_index(grant_idx, 1);
      end
      if (pop) rd_d = rd_q + 1'b1;
      cnt_d = cnt_q + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};

      for (int i = 0; i < NUM_CORES; i++) begin
        if (core_found[i]) begin
          if (slot_full_d[i]) begin
            n_drops = n_drops + 5'd1;
          end else begin
            slot_full_d[i]           = 1'b1;
            slot_nonce_d[32*i +: 32] = core_nonce[32*i +: 32];
          end
        end
      end
      drop_sum = {1'b0, drop_q} + {4'b0, n_drops};
      drop_d   = (drop_sum > 9'd255) ? 8'hFF : drop_sum[7:0];
      if (n_drops != '0) overflow_d = 1'b1;
    end
  end

  always_ff @(posedge hash_clk or negedge reset_n) begin
    if (!reset_n) begin
      min_q        <= '0;
      max_q        <= '0;
      en_q         <= '0;
      core_reset_q <= 1'b0;
      range_err_q  <= 1'b0;
      overflow_q   <= 1'b0;
      drop_q       <= '0;
      slot_full_q  <= '0;
      slot_nonce_q <= '0;
      rr_q         <= '0;
      wr_q         <= '0;
      rd_q         <= '0;
      cnt_q        <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_nonce_q[i] <= '0;
        fifo_core_q[i]  <= '0;
      end
    end else begin
      min_q        <= min_d;
      max_q        <= max_d;
      en_q         <= en_d;
      core_reset_q <= core_reset_d;
      range_err_q  <= range_err_d;
      overflow_q   <= overflow_d;
      drop_q       <= drop_d;
      slot_full_q  <= slot_full_d;
      slot_nonce_q <= slot_nonce_d;
      rr_q         <= rr_d;
      wr_q         <= wr_d;
      rd_q         <= rd_d;
      cnt_q        <= cnt_d;
      fifo_nonce_q <= fifo_nonce_d;
      fifo_core_q  <= fifo_core_d;
    end
  end

  assign core_nonce_min = min_q;
  assign core_nonce_max = max_q;
  assign core_en        = en_q;
  assign core_reset     = core_reset_q;
  assign range_err      = range_err_q;
  assign overflow       = overflow_q;
  assign drop_cnt       = drop_q;
  assign out_valid      = (cnt_q != '0);
  assign out_nonce      = fifo_nonce_q[rd_q];
  assign out_core       = fifo_core_q[rd_q];

endmodule

// File: tb/tb_miner_array_ctrl.sv
// Self-checking bench for miner_array_ctrl: directed scenarios, then random traffic,
// every cycle compared against a queue-based reference model.
module tb_miner_array_ctrl;

  localparam int CORE_LOG2  = 2;
  localparam int NUM_CORES  = 4;
  localparam int FIFO_DEPTH = 8;
  localparam int CW         = 2;

  logic                    hash_clk;
  logic                    reset_n;
  logic                    new_work;
  logic [31:0]             nonce_min, nonce_max;
  logic [32*NUM_CORES-1:0] core_nonce_min, core_nonce_max;
  logic [NUM_CORES-1:0]    core_en;
  logic                    core_reset;
  logic [NUM_CORES-1:0]    core_found;
  logic [32*NUM_CORES-1:0] core_nonce;
  logic                    out_valid, out_ready;
  logic [31:0]             out_nonce;
  logic [CW-1:0]           out_core;
  logic                    range_err, overflow;
  logic [7:0]              drop_cnt;

  miner_array_ctrl #(.CORE_LOG2(CORE_LOG2), .FIFO_DEPTH(FIFO_DEPTH), .FLUSH_ON_WORK(1)) dut (
    .hash_clk(hash_clk), .reset_n(reset_n), .new_work(new_work),
    .nonce_min(nonce_min), .nonce_max(nonce_max),
    .core_nonce_min(core_nonce_min), .core_nonce_max(core_nonce_max),
    .core_en(core_en), .core_reset(core_reset),
    .core_found(core_found), .core_nonce(core_nonce),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_nonce(out_nonce), .out_core(out_core),
    .range_err(range_err), .overflow(overflow), .drop_cnt(drop_cnt)
  );

  initial hash_clk = 1'b0;
  always #5 hash_clk = ~hash_clk;

  typedef struct packed {
    logic [CW-1:0] core;
    logic [31:0]   nonce;
  } result_t;

  result_t              m_fifo[$];
  logic [31:0]          m_min [NUM_CORES];
  logic [31:0]          m_max [NUM_CORES];
  logic [NUM_CORES-1:0] m_en;
  bit                   m_reset, m_rerr, m_ovf;
  int                   m_drops;
  bit                   m_slot_v [NUM_CORES];
  logic [31:0]          m_slot_n [NUM_CORES];
  int                   m_rr;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_fifo.delete();
    for (int i = 0; i < NUM_CORES; i++) begin
      m_min[i] = '0; m_max[i] = '0; m_slot_v[i] = 0; m_slot_n[i] = '0;
    end
    m_en = '0; m_reset = 0; m_rerr = 0; m_ovf = 0; m_drops = 0; m_rr = 0;
  endtask

  // Advance the reference model by one clock using the inputs present now
  task automatic model_step();
    longint span, chunk;
    bit     full, job_ok;
    int     g;
    result_t r;
    job_ok  = new_work && (nonce_min <= nonce_max);
    m_reset = job_ok;
    if (new_work) m_rerr = !job_ok;
    if (job_ok) begin
      span  = longint'(nonce_max) - longint'(nonce_min) + 1;
      chunk = span / NUM_CORES;
      for (int i = 0; i < NUM_CORES; i++) begin
        if (chunk == 0) begin
          m_min[i] = nonce_min; m_max[i] = nonce_max; m_en[i] = (i == 0);
        end else begin
          m_min[i] = 32'(longint'(nonce_min) + longint'(i) * chunk);
          m_max[i] = (i == NUM_CORES-1) ? nonce_max
                     : 32'(longint'(nonce_min) + longint'(i+1) * chunk - 1);
          m_en[i]  = 1'b1;
        end
      end
    end
    full = (m_fifo.size() == FIFO_DEPTH);
    if (m_fifo.size() > 0 && out_ready) void'(m_fifo.pop_front());
    if (job_ok) begin
      m_fifo.delete();
      for (int i = 0; i < NUM_CORES; i++) m_slot_v[i] = 0;
    end else begin
      if (!full) begin
        g = -1;
        for (int k = 0; k < NUM_CORES; k++)
          if (g < 0 && m_slot_v[(m_rr + k) % NUM_CORES]) g = (m_rr + k) % NUM_CORES;
        if (g >= 0) begin
          r.core = CW'(g); r.nonce = m_slot_n[g];
          m_fifo.push_back(r);
          m_slot_v[g] = 0;
          m_rr = (g + 1) % NUM_CORES;
        end
      end
      for (int i = 0; i < NUM_CORES; i++) begin
        if (core_found[i]) begin
          if (m_slot_v[i]) begin
            m_ovf = 1;
            if (m_drops < 255) m_drops++;
          end else begin
            m_slot_v[i] = 1; m_slot_n[i] = core_nonce[32*i +: 32];
          end
        end
      end
    end
  endtask

  task automatic checkOutput();
    chk("core_reset", 32'(core_reset), 32'(m_reset));
    chk("range_err", 32'(range_err), 32'(m_rerr));
    chk("core_en", 32'(core_en), 32'(m_en));
    for (int i = 0; i < NUM_CORES; i++) begin
      chk($sformatf("min%0d", i), core_nonce_min[32*i +: 32], m_min[i]);
      chk($sformatf("max%0d", i), core_nonce_max[32*i +: 32], m_max[i]);
    end
    chk("out_valid", 32'(out_valid), 32'(m_fifo.size() != 0));
    if (m_fifo.size() != 0) begin
      chk("out_nonce", out_nonce, m_fifo[0].nonce);
      chk("out_core", 32'(out_core), 32'(m_fifo[0].core));
    end
    chk("overflow", 32'(overflow), 32'(m_ovf));
    chk("drop_cnt", 32'(drop_cnt), 32'(m_drops));
  endtask

  task automatic applyStimulus();
    model_step();
    @(posedge hash_clk);
    #1;
    new_work   = 1'b0;
    core_found = '0;
    checkOutput();
  endtask

  task automatic job(input logic [31:0] lo, input logic [31:0] hi);
    new_work = 1'b1; nonce_min = lo; nonce_max = hi;
    applyStimulus();
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    model_reset();
    repeat (2) @(posedge hash_clk);
    #1;
    checkOutput();
    reset_n = 1'b1;
  endtask

  initial begin
    reset_n = 1'b0; new_work = 1'b0; nonce_min = '0; nonce_max = '0;
    core_found = '0; core_nonce = '0; out_ready = 1'b0;
    do_reset();

    $display("[TB] full-range split");
    job(32'h0, 32'hFFFF_FFFF);
    chk("t1_reset", 32'(core_reset), 32'd1);
    chk("t1_c0_max", core_nonce_max[31:0], 32'h3FFF_FFFF);
    chk("t1_c1_min", core_nonce_min[63:32], 32'h4000_0000);
    chk("t1_c1_max", core_nonce_max[63:32], 32'h7FFF_FFFF);
    chk("t1_c3_min", core_nonce_min[127:96], 32'hC000_0000);
    chk("t1_c3_max", core_nonce_max[127:96], 32'hFFFF_FFFF);
    chk("t1_en", 32'(core_en), 32'hF);
    applyStimulus();
    chk("t1_reset_drop", 32'(core_reset), 32'd0);

    $display("[TB] small ranges");
    job(32'd10, 32'd20);
    chk("t2_c2_min", core_nonce_min[95:64], 32'd14);
    chk("t2_c3_max", core_nonce_max[127:96], 32'd20);
    job(32'd5, 32'd6);
    chk("t2_en", 32'(core_en), 32'h1);
    chk("t2_c0_max", core_nonce_max[31:0], 32'd6);

    $display("[TB] simultaneous founds");
    do_reset();
    core_found = 4'b1010;
    core_nonce = {32'hBBBB_0003, 32'h0, 32'hAAAA_0001, 32'h0};
    applyStimulus();
    applyStimulus();
    chk("t3_head_core", 32'(out_core), 32'd1);
    chk("t3_head_nonce", out_nonce, 32'hAAAA_0001);
    applyStimulus();
    out_ready = 1'b1;
    applyStimulus();
    chk("t3_second_core", 32'(out_core), 32'd3);
    chk("t3_second_nonce", out_nonce, 32'hBBBB_0003);
    applyStimulus();
    out_ready = 1'b0;

    $display("[TB] overflow");
    for (int j = 0; j < 10; j++) begin
      core_found = 4'b0001;
      core_nonce = {96'h0, 32'h1000_0000 + 32'(j)};
      applyStimulus();
    end
    chk("t4_overflow", 32'(overflow), 32'd1);
    chk("t4_drop", 32'(drop_cnt), 32'd1);
    out_ready = 1'b1;
    for (int j = 0; j < 9; j++) begin
      chk($sformatf("t4_drain%0d", j), out_nonce, 32'h1000_0000 + 32'(j));
      applyStimulus();
    end
    chk("t4_empty", 32'(out_valid), 32'd0);
    out_ready = 1'b0;

    $display("[TB] inverted range");
    job(32'd100, 32'd50);
    chk("t5_err", 32'(range_err), 32'd1);
    chk("t5_no_reset", 32'(core_reset), 32'd0);
    job(32'd0, 32'd999);
    chk("t5_err_clr", 32'(range_err), 32'd0);

    $display("[TB] flush");
    core_found = 4'b0111;
    core_nonce = {32'h0, 32'h3333_0000, 32'h2222_0000, 32'h1111_0000};
    repeat (4) applyStimulus();
    job(32'h0, 32'hFFFF);
    chk("t6_flushed", 32'(out_valid), 32'd0);
    chk("t6_ovf_kept", 32'(overflow), 32'd1);

    $display("[TB] random traffic");
    for (int c = 0; c < 400; c++) begin
      core_found = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'b0;
      core_nonce = {$urandom, $urandom, $urandom, $urandom};
      out_ready  = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 39) == 0) begin
        new_work  = 1'b1;
        nonce_min = $urandom;
        case ($urandom_range(0, 2))
          0:       nonce_max = nonce_min + 32'($urandom_range(0, 6));
          1:       nonce_max = $urandom;
          default: nonce_max = nonce_min + 32'($urandom_range(0, 100000));
        endcase
      end
      applyStimulus();
    end

    $display("[TB] async reset mid-job");
    core_found = 4'b1111;
    applyStimulus();
    job(32'h0, 32'hFFFF_FFFF);
    #2;
    reset_n = 1'b0;
    #1;
    chk("rst_core_reset", 32'(core_reset), 32'd0);
    chk("rst_en", 32'(core_en), 32'd0);
    chk("rst_min", 32'(|core_nonce_min), 32'd0);
    chk("rst_max", 32'(|core_nonce_max), 32'd0);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_nonce", out_nonce, 32'd0);
    chk("rst_ovf", 32'(overflow), 32'd0);
    chk("rst_drop", 32'(drop_cnt), 32'd0);
    chk("rst_err", 32'(range_err), 32'd0);
    model_reset();
    @(posedge hash_clk);
    #1;
    reset_n = 1'b1;
    applyStimulus();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/miner_array_ctrl.md
Name: miner_array_ctrl

Overview:
Job-distribution and result-collection controller for a multi-core miner top: a parametrised successor to the single-core miner top.
- Takes one job nonce range from the UART front end, splits it evenly across NUM_CORES hash cores and pulses their reset to start them.
- Captures golden nonces from all cores and queues them, tagged with core index, toward the UART transmitter through a valid/ready FIFO.
- Sits entirely in the hash_clk domain, between uart_comm and an array of fpgaminer_top instances.

Parameters:
CORE_LOG2, 2, log2 of core count; NUM_CORES = 2**CORE_LOG2 (1..16 cores).
FIFO_DEPTH, 8, result FIFO entries, power of 2, >=2.
FLUSH_ON_WORK, 1, 1 = new_work empties FIFO and pending slots; 0 = queued results survive new_work.

Ports:
hash_clk  in  1  sole clock.
reset_n  in  1  asynchronous, active-low reset.
new_work  in  1  one-cycle pulse; nonce_min/nonce_max valid on this cycle.
nonce_min  in  32  job first nonce.
nonce_max  in  32  job last nonce, inclusive.
core_nonce_min  out  32*NUM_CORES  per-core first nonce; core i at bits [32i+31:32i].
core_nonce_max  out  32*NUM_CORES  per-core last nonce, same packing.
core_en  out  NUM_CORES  core i assigned work.
core_reset  out  1  one-cycle start pulse to all cores.
core_found  in  NUM_CORES  per-core new_golden_nonce pulses.
core_nonce  in  32*NUM_CORES  per-core golden_nonce, same packing.
out_valid  out  1  FIFO head valid.
out_ready  in  1  consumer accepts head.
out_nonce  out  32  head nonce.
out_core  out  CORE_LOG2  head core index (width max(1,CORE_LOG2)).
range_err  out  1  last new_work had nonce_min > nonce_max.
overflow  out  1  sticky: a result was dropped.
drop_cnt  out  8  dropped-result count, saturates at 255.

Behaviour:
- Reset (async assert, sync release): all outputs 0, FIFO empty, pending slots clear, RR pointer 0.
- Split (registered, latency 1): new_work sampled at cycle T -> core_nonce_*, core_en, core_reset valid at T+1; core_reset high exactly one cycle.
  - span = nonce_max - nonce_min + 1, computed at 33 bits (0..FFFFFFFF gives 2^32).
  - chunk = span >> CORE_LOG2.
  - core i min = nonce_min + i*chunk; max = min + chunk - 1; last core max = nonce_max (absorbs the remainder).
  - All cores enabled.
- span < NUM_CORES (chunk == 0): core 0 gets [nonce_min, nonce_max]; core_en = 1 for core 0 only; other cores' ranges = core 0's.
- nonce_min > nonce_max: range_err = 1 from T+1; no core_reset pulse; assignment, core_en and FIFO unchanged. range_err clears on the next valid new_work.
- Capture: one pending slot per core.
  - core_found[i] with slot empty: latch core_nonce[i]; slot full from the next cycle.
  - core_found[i] with slot full: drop the new value, set overflow, increment drop_cnt.
- Arbitration: each cycle, if FIFO not full, grant the first full slot at or after the RR pointer (wrapping). Push {core, nonce}; clear that slot; pointer = grant+1. At most one push per cycle.
- Found pulse and grant on the same slot in the same cycle: the slot refills with the new value; no drop.
- FIFO:
  - out_valid = not empty; out_nonce/out_core reflect the head combinationally from registers.
  - Pop on out_valid & out_ready.
  - Push is blocked when full at cycle start, even if a pop occurs that cycle.
  - Simultaneous push and pop when not full: count unchanged.
- new_work with FLUSH_ON_WORK=1: FIFO and pending slots cleared at T+1; found pulses in cycle T are discarded. overflow and drop_cnt are kept and cleared only by reset.
- Reset asserted mid-job: immediate return to reset state, including dropping core_reset.

Test Plan:
1. CORE_LOG2=2; new_work, min=0, max=FFFFFFFF -> at T+1 core_reset=1 for 1 cycle; core0 0..3FFFFFFF, core1 40000000..7FFFFFFF, core3 C0000000..FFFFFFFF; core_en=1111.
2. min=10, max=20 -> chunk 2; core0 10..11, core1 12..13, core2 14..15, core3 16..20. Then min=5, max=6 -> core_en=0001, core0 5..6.
3. core_found=1010 in the same cycle with nonces AAAA0001/BBBB0003, RR pointer 0 -> FIFO emits (core1, AAAA0001) then (core3, BBBB0003).
4. FIFO_DEPTH=8, out_ready=0, 10 single pulses from core 0 -> 8 queued, 1 pending, 1 dropped; overflow=1, drop_cnt=1. Raise out_ready -> 9 results drained in order.
5. min=100, max=50 -> range_err=1, no core_reset pulse, previous ranges held. Next valid job clears range_err.
6. 3 results queued, new_work with FLUSH_ON_WORK=1 -> out_valid=0 at T+1, overflow unchanged. Assert reset_n=0 mid-job -> all outputs 0 asynchronously.
